// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider with square/pulse outputs, per-channel enable,
// common phase-align and a channel-0 period counter used as the game time base.
module clk_div_bank #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DIV_INIT = 499999
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic [N_CH-1:0]   mode,
  input  logic              sync,
  input  logic              div_load,
  input  logic [2:0]        div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [N_CH-1:0]   out_clk,
  output logic [N_CH-1:0]   tick,
  output logic [15:0]       time_cnt
);

  localparam logic [CNT_W-1:0] DivInit = CNT_W'(DIV_INIT);

  logic [N_CH-1:0] period_done;
  logic [15:0]     time_cnt_q, time_cnt_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             load_hit;
    logic             wrap;

    always_comb begin
      load_hit = div_load && (div_ch == 3'(i));
      wrap     = en[i] && (count_q == act_q);
      shd_d    = load_hit ? div_val : shd_q;
      count_d  = count_q;
      act_d    = act_q;
      out_d    = out_q;
      tick_d   = 1'b0;

      // A load landing on a ratio boundary (disabled, wrap or sync) bypasses the shadow.
      if (load_hit && (!en[i] || wrap || sync)) begin
        act_d = div_val;
      end else if (wrap || sync) begin
        act_d = shd_q;
      end

      if (sync) begin
        count_d = '0;
        out_d   = 1'b0;
      end else if (en[i]) begin
        count_d = wrap ? '0 : count_q + CNT_W'(1);
        tick_d  = wrap;
        out_d   = mode[i] ? wrap : (out_q ^ wrap);
      end else if (mode[i]) begin
        out_d = 1'b0;
      end
    end

    always_ff @(posedge in_clk or posedge rst) begin
      if (rst) begin
        count_q <= '0;
        act_q   <= DivInit;
        shd_q   <= DivInit;
        out_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        count_q <= count_d;
        act_q   <= act_d;
        shd_q   <= shd_d;
        out_q   <= out_d;
        tick_q  <= tick_d;
      end
    end

    // A full period ends on the falling toggle (square) or on every wrap (pulse).
    assign period_done[i] = !sync && wrap && (mode[i] || out_q);
    assign out_clk[i]     = out_q;
    assign tick[i]        = tick_q;
  end

  always_comb begin
    time_cnt_d = time_cnt_q;
    if (period_done[0]) begin
      time_cnt_d = time_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      time_cnt_q <= 16'hFFFF;
    end else begin
      time_cnt_q <= time_cnt_d;
    end
  end

  assign time_cnt = time_cnt_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank.
module tb_clk_div_bank;

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned N_CH     = 4;
  localparam int unsigned DIV_INIT = 6;

  logic             in_clk;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  mode;
  logic             sync;
  logic             div_load;
  logic [2:0]       div_ch;
  logic [CNT_W-1:0] div_val;
  logic [N_CH-1:0]  out_clk;
  logic [N_CH-1:0]  tick;
  logic [15:0]      time_cnt;

  int n_checks;
  int n_fail;

  clk_div_bank #(
    .CNT_W    (CNT_W),
    .N_CH     (N_CH),
    .DIV_INIT (DIV_INIT)
  ) dut (
    .in_clk   (in_clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sync     (sync),
    .div_load (div_load),
    .div_ch   (div_ch),
    .div_val  (div_val),
    .out_clk  (out_clk),
    .tick     (tick),
    .time_cnt (time_cnt)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic cyc();
    @(posedge in_clk);
    @(negedge in_clk);
  endtask

  task automatic load(input int ch, input logic [CNT_W-1:0] val);
    div_load = 1'b1;
    div_ch   = 3'(ch);
    div_val  = val;
    cyc();
    div_load = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; mode = '0; sync = 1'b0;
    div_load = 1'b0; div_ch = '0; div_val = '0;
    repeat (3) @(negedge in_clk);
    n_checks++;
    if (out_clk !== 4'b0000) begin
      n_fail++; $display("FAIL reset_out_clk: got %b expected %b", out_clk, 4'b0000);
    end
    n_checks++;
    if (tick !== 4'b0000) begin
      n_fail++; $display("FAIL reset_tick: got %b expected %b", tick, 4'b0000);
    end
    n_checks++;
    if (time_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_time_cnt: got %h expected %h", time_cnt, 16'hFFFF);
    end
    rst = 1'b0;
    cyc();
    n_checks++;
    if (out_clk !== 4'b0000 || tick !== 4'b0000) begin
      n_fail++; $display("FAIL idle_after_reset: got %b/%b expected 0000/0000", out_clk, tick);
    end
  endtask

  task automatic test_square_ch0();
    logic [15:0] exp_tc;
    load(0, 3); load(1, 4); load(2, 9); load(3, 5);
    mode = 4'b0010;
    en   = 4'b1111;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      exp_tc = 16'hFFFF + 16'(k / 8);
      n_checks++;
      if (tick[0] !== (k % 4 == 0)) begin
        n_fail++; $display("FAIL sq_tick k=%0d: got %b expected %b", k, tick[0], (k % 4 == 0));
      end
      n_checks++;
      if (out_clk[0] !== ((k / 4) % 2 == 1)) begin
        n_fail++;
        $display("FAIL sq_out k=%0d: got %b expected %b", k, out_clk[0], ((k / 4) % 2 == 1));
      end
      n_checks++;
      if (time_cnt !== exp_tc) begin
        n_fail++; $display("FAIL sq_time_cnt k=%0d: got %h expected %h", k, time_cnt, exp_tc);
      end
    end
  endtask

  task automatic test_pulse_ch1();
    pulse_sync();
    n_checks++;
    if (out_clk !== 4'b0000 || tick !== 4'b0000) begin
      n_fail++; $display("FAIL sync_clear: got %b/%b expected 0000/0000", out_clk, tick);
    end
    for (int k = 1; k <= 15; k++) begin
      cyc();
      n_checks++;
      if (out_clk[1] !== (k % 5 == 0) || tick[1] !== (k % 5 == 0)) begin
        n_fail++;
        $display("FAIL pulse_d4 k=%0d: got out=%b tick=%b expected %b", k, out_clk[1], tick[1],
                 (k % 5 == 0));
      end
    end
    en[1] = 1'b0;
    load(1, 0);
    en[1] = 1'b1;
    pulse_sync();
    n_checks++;
    if (out_clk[1] !== 1'b0) begin
      n_fail++; $display("FAIL pulse_d0_sync: got %b expected 0", out_clk[1]);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      n_checks++;
      if (out_clk[1] !== 1'b1 || tick[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL pulse_d0 k=%0d: got out=%b tick=%b expected 1", k, out_clk[1], tick[1]);
      end
    end
  endtask

  task automatic test_reload_ch2();
    logic exp_t;
    int   n_wrap;
    n_wrap = 0;
    pulse_sync();
    for (int k = 1; k <= 31; k++) begin
      cyc();
      div_load = 1'b0;
      exp_t = (k == 10 || k == 13 || k == 16 || k == 19 || k == 25 || k == 31);
      if (exp_t) n_wrap++;
      n_checks++;
      if (tick[2] !== exp_t) begin
        n_fail++; $display("FAIL reload_tick k=%0d: got %b expected %b", k, tick[2], exp_t);
      end
      n_checks++;
      if (out_clk[2] !== n_wrap[0]) begin
        n_fail++; $display("FAIL reload_out k=%0d: got %b expected %b", k, out_clk[2], n_wrap[0]);
      end
      if (k == 5) begin
        div_load = 1'b1; div_ch = 3'd2; div_val = 2;
      end
      if (k == 18) begin
        div_load = 1'b1; div_ch = 3'd2; div_val = 5;
      end
    end
  endtask

  task automatic check_aligned(input string tag);
    logic [3:0] exp_t;
    logic [3:0] exp_o;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_t = {k % 6 == 0, k % 6 == 0, 1'b1, k % 4 == 0};
      exp_o = {(k / 6) % 2 == 1, (k / 6) % 2 == 1, k % 2 == 1, (k / 4) % 2 == 1};
      n_checks++;
      if (tick !== exp_t) begin
        n_fail++; $display("FAIL %s_tick k=%0d: got %b expected %b", tag, k, tick, exp_t);
      end
      n_checks++;
      if (out_clk !== exp_o) begin
        n_fail++; $display("FAIL %s_out k=%0d: got %b expected %b", tag, k, out_clk, exp_o);
      end
    end
  endtask

  task automatic test_sync_align();
    mode = 4'b0000;
    repeat (7) cyc();
    pulse_sync();
    n_checks++;
    if (out_clk !== 4'b0000 || tick !== 4'b0000) begin
      n_fail++; $display("FAIL align_sync: got %b/%b expected 0000/0000", out_clk, tick);
    end
    check_aligned("align");
  endtask

  task automatic test_enable_ch3();
    logic exp_t;
    logic exp_o;
    pulse_sync();
    for (int k = 1; k <= 26; k++) begin
      cyc();
      exp_t = (k == 6 || k == 19 || k == 25);
      exp_o = (k >= 6 && k < 19) || (k >= 25);
      n_checks++;
      if (tick[3] !== exp_t) begin
        n_fail++; $display("FAIL en_tick k=%0d: got %b expected %b", k, tick[3], exp_t);
      end
      n_checks++;
      if (out_clk[3] !== exp_o) begin
        n_fail++; $display("FAIL en_out k=%0d: got %b expected %b", k, out_clk[3], exp_o);
      end
      if (k == 8) en[3] = 1'b0;
      if (k == 15) en[3] = 1'b1;
    end
    load(5, 1);
    pulse_sync();
    check_aligned("bad_ch");
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] exp_v;
    @(negedge in_clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_clk !== 4'b0000 || tick !== 4'b0000) begin
      n_fail++; $display("FAIL async_rst_out: got %b/%b expected 0000/0000", out_clk, tick);
    end
    n_checks++;
    if (time_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL async_rst_time_cnt: got %h expected %h", time_cnt, 16'hFFFF);
    end
    @(negedge in_clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      exp_v = (k == 7) ? 4'b1111 : 4'b0000;
      n_checks++;
      if (tick !== exp_v) begin
        n_fail++; $display("FAIL init_ratio_tick k=%0d: got %b expected %b", k, tick, exp_v);
      end
      exp_v = (k >= 7) ? 4'b1111 : 4'b0000;
      n_checks++;
      if (out_clk !== exp_v) begin
        n_fail++; $display("FAIL init_ratio_out k=%0d: got %b expected %b", k, out_clk, exp_v);
      end
    end
    n_checks++;
    if (time_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL init_ratio_time_cnt: got %h expected %h", time_cnt, 16'hFFFF);
    end
  endtask

  task automatic test_time_wrap();
    rst  = 1'b1;
    en   = 4'b0000;
    mode = 4'b0001;
    @(negedge in_clk);
    rst = 1'b0;
    load(0, 0);
    en = 4'b0001;
    for (int k = 1; k <= 65537; k++) begin
      cyc();
      if (k == 1) begin
        n_checks++;
        if (time_cnt !== 16'h0000) begin
          n_fail++; $display("FAIL tc_first: got %h expected %h", time_cnt, 16'h0000);
        end
      end
      if (k == 65536) begin
        n_checks++;
        if (time_cnt !== 16'hFFFF) begin
          n_fail++; $display("FAIL tc_full: got %h expected %h", time_cnt, 16'hFFFF);
        end
      end
      if (k == 65537) begin
        n_checks++;
        if (time_cnt !== 16'h0000) begin
          n_fail++; $display("FAIL tc_wrap: got %h expected %h", time_cnt, 16'h0000);
        end
        n_checks++;
        if (out_clk !== 4'b0001 || tick !== 4'b0001) begin
          n_fail++; $display("FAIL tc_wrap_side: got %b/%b expected 0001/0001", out_clk, tick);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_square_ch0();
    test_pulse_ch1();
    test_reload_ch2();
    test_sync_align();
    test_enable_ch3();
    test_reset_mid_run();
    test_time_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
